sha256_digest_reader: RTL

//   Reads out the final SHA-256 hash state (H0..H7, eight 32-bit words) after compression completes.

---
 rtl/sha256_pkg.sv | 25 ++
 rtl/sha256_digest_buffer.sv | 42 ++++
 rtl/sha256_digest_reader.sv | 99 +++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared sizes, FSM state type and SHA-256 initial hash values.
// No logic; constants only.
// Imported by the digest reader, its buffer and the bench.
package sha256_pkg;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 8;
    localparam int DIGEST_W  = WORD_W * NUM_WORDS;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // FIPS 180-4 initial hash values H0..H7
    localparam logic [31:0] H0_INIT = 32'h6a09e667;
    localparam logic [31:0] H1_INIT = 32'hbb67ae85;
    localparam logic [31:0] H2_INIT = 32'h3c6ef372;
    localparam logic [31:0] H3_INIT = 32'ha54ff53a;
    localparam logic [31:0] H4_INIT = 32'h510e527f;
    localparam logic [31:0] H5_INIT = 32'h9b05688c;
    localparam logic [31:0] H6_INIT = 32'h1f83d9ab;
    localparam logic [31:0] H7_INIT = 32'h5be0cd19;

endpackage

// File: rtl/sha256_digest_buffer.sv
// Shadow register file holding one digest snapshot, read by word index.
// Capture on the load edge; read is combinational from the registers.
// No backpressure of its own; the reader decides when to load and advance.
module sha256_digest_buffer
    import sha256_pkg::*;
#(
    parameter int WORD_W    = sha256_pkg::WORD_W,
    parameter int NUM_WORDS = sha256_pkg::NUM_WORDS,
    parameter bit MSW_FIRST = 1'b1,
    parameter int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        load,
    input  logic [WORD_W*NUM_WORDS-1:0] digest_i,
    input  logic [IDX_W-1:0]            rd_idx,
    output logic [WORD_W-1:0]           rd_data
);

    // Stored in emission order, so entry 0 is always the first word out.
    logic [WORD_W-1:0] mem [NUM_WORDS];

    // Snapshot every word of the digest on the same edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (MSW_FIRST) begin
                    mem[i] <= digest_i[(NUM_WORDS-1-i)*WORD_W +: WORD_W];
                end else begin
                    mem[i] <= digest_i[i*WORD_W +: WORD_W];
                end
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/sha256_digest_reader.sv
// Snapshots the final SHA-256 state and streams it as NUM_WORDS words.
// Latency: load at edge N -> word 0 valid during cycle N+1; one word/cycle.
// Backpressure: out_data/out_last hold while out_valid && !out_ready.
module sha256_digest_reader
    import sha256_pkg::*;
#(
    parameter int WORD_W    = sha256_pkg::WORD_W,
    parameter int NUM_WORDS = sha256_pkg::NUM_WORDS,
    parameter bit MSW_FIRST = 1'b1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        flush,
    input  logic                        load,
    input  logic [WORD_W*NUM_WORDS-1:0] digest_i,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WORD_W-1:0]           out_data,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);

    localparam int               IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] rd_data;
    logic              load_acc;

    // A load is only taken from IDLE and never alongside a flush, so a
    // snapshot in flight is never overwritten.
    assign load_acc = load && !flush && (state == IDLE);

    sha256_digest_buffer #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS),
        .MSW_FIRST (MSW_FIRST),
        .IDX_W     (IDX_W)
    ) u_buffer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (load_acc),
        .digest_i (digest_i),
        .rd_idx   (idx),
        .rd_data  (rd_data)
    );

    // Readout FSM: word index, handshake and registered valid/done.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            idx       <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state     <= IDLE;
                idx       <= '0;
                out_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (load) begin
                            state     <= STREAM;
                            idx       <= '0;
                            out_valid <= 1'b1;
                        end
                    end
                    STREAM: begin
                        if (out_ready) begin
                            if (idx == LAST_IDX) begin
                                state     <= IDLE;
                                idx       <= '0;
                                out_valid <= 1'b0;
                                done      <= 1'b1;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        idx       <= '0;
                        out_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Data is muxed straight from registers, so it is stable while stalled.
    assign out_data = out_valid ? rd_data : '0;
    assign out_last = out_valid && (idx == LAST_IDX);
    assign busy     = (state != IDLE);

endmodule
